// File: rtl/bus_display_scanner_pkg.sv
// Shared constants for the bus display scanner: capture modes, blank code and
// the active-low gfedcba hex font.
package bus_display_pkg;

    localparam logic [1:0] MODE_LIVE    = 2'b00;
    localparam logic [1:0] MODE_CAPTURE = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/bus_display_scanner_if.sv
// Bus probe bundle feeding the display scanner: observed bus plus display controls.
interface bus_display_scanner_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              bus_valid;
    logic [1:0]        mode;
    logic              lzb;

    modport master (output address, data, bus_valid, mode, lzb);
    modport slave  (input  address, data, bus_valid, mode, lzb);
endinterface

// File: rtl/bus_display_scanner_hex_seg_decoder.sv
// Nibble to active-low seven-segment pattern; blank forces all segments off.
module hex_seg_decoder
    import bus_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);
    assign pattern = blank ? SEG_BLANK[6:0] : HEX_SEG[nibble];
endmodule

// File: rtl/bus_display_scanner.sv
// Multiplexed seven-segment scanner showing captured address/data nibbles with
// per-slot anti-ghost blanking, leading-zero blanking and an activity DP.
module bus_display_scanner
    import bus_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 2000,
    parameter int ACT_CYC    = 10000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_display_scanner_if.slave  bus,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);
    localparam int ADDR_DIG = ADDR_W / 4;
    localparam int DATA_LO  = NUM_DIGITS - DATA_W / 4;
    localparam int DIV_W    = $clog2(SCAN_DIV);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int ACT_W    = $clog2(ACT_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ACT_W-1:0] ACT_LOAD  = ACT_W'(ACT_CYC);

    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [ACT_W-1:0]  act_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    logic              load, hold, div_last, wrap;

    assign hold     = bus.mode[1];
    assign load     = (bus.mode == MODE_LIVE) || (bus.mode == MODE_CAPTURE && bus.bus_valid);
    assign div_last = (div_cnt == DIV_LAST);
    assign wrap     = div_last && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr <= '0;
            cap_data <= '0;
            act_cnt  <= '0;
        end else begin
            if (load) begin
                cap_addr <= bus.address;
                cap_data <= bus.data;
            end
            if (bus.bus_valid && !hold)
                act_cnt <= ACT_LOAD;
            else if (act_cnt != '0)
                act_cnt <= act_cnt - ACT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_last) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Every digit is decoded in parallel; the scan index just picks one.
    logic [NUM_DIGITS-1:0][6:0] pat;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        logic [3:0] nib;
        logic       blk;
        if (d < ADDR_DIG) begin : g_addr
            assign nib = cap_addr[4*d +: 4];
            if (d == 0) begin : g_lsn
                assign blk = 1'b0;
            end else begin : g_msn
                assign blk = bus.lzb && (cap_addr[ADDR_W-1:4*d] == '0);
            end
        end else if (d >= DATA_LO) begin : g_data
            assign nib = cap_data[4*(d-DATA_LO) +: 4];
            if (d == DATA_LO) begin : g_lsn
                assign blk = 1'b0;
            end else begin : g_msn
                assign blk = bus.lzb && (cap_data[DATA_W-1:4*(d-DATA_LO)] == '0);
            end
        end else begin : g_gap
            assign nib = '0;
            assign blk = 1'b1;
        end
        hex_seg_decoder u_dec (.nibble(nib), .blank(blk), .pattern(pat[d]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (div_cnt < BLANK_END) begin
                seg <= SEG_BLANK;
                an  <= '1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= {~(idx == '0 && act_cnt != '0), pat[idx]};
            end
        end
    end

endmodule

// File: tb/tb_bus_display_scanner.sv
// Directed bench for bus_display_scanner with 8 digits, 4-clock slots, 1 blank clock.
module tb_bus_display_scanner;

    localparam logic [63:0] LIVE_TBL = 64'hB0C6_FFFF_F9A4_888E;
    localparam logic [63:0] CAP_TBL  = 64'hC0C0_FFFF_C0C0_99C0;
    localparam logic [63:0] LZB_TBL  = 64'hFFC0_FFFF_FFFF_99C0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg;
    logic [7:0] an;
    logic       frame_tick;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;

    bus_display_scanner_if #(.ADDR_W(16), .DATA_W(8)) bus_if ();

    bus_display_scanner #(
        .NUM_DIGITS(8), .ADDR_W(16), .DATA_W(8),
        .SCAN_DIV(4), .BLANK_CYC(1), .ACT_CYC(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Edges since reset release; output after edge k shows slot (k-1).
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] tbl);
        int slot, dig, ticks;
        logic [7:0] exp_an, exp_seg;
        ticks = 0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            slot    = (cyc - 1) % 4;
            dig     = ((cyc - 1) / 4) % 8;
            exp_an  = (slot == 0) ? 8'hFF : ~(8'h01 << dig);
            exp_seg = (slot == 0) ? 8'hFF : tbl[8*dig +: 8];
            chk({tag, "_an"}, an, exp_an);
            chk({tag, "_seg"}, seg, exp_seg);
            chk({tag, "_tick"}, frame_tick, (cyc % 32 == 0));
            if (frame_tick) ticks++;
        end
        chk({tag, "_ticks"}, ticks, 1);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_if.address   = 16'h12AF;
        bus_if.data      = 8'h3C;
        bus_if.bus_valid = 1'b0;
        bus_if.mode      = 2'b00;
        bus_if.lzb       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_tick", frame_tick, 0);
        chk("rst_act", dut.act_cnt, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel1_an", an, 8'hFF);
        @(negedge clk);
        chk("rel2_an", an, 8'hFE);
        chk("rel2_seg", seg, 8'h8E);

        check_frame("live", LIVE_TBL);

        // Capture mode: bus wanders without strobes, then one strobe lands at cyc%32==20.
        bus_if.mode = 2'b01;
        for (int n = 0; n < 64 && (cyc % 32) != 19; n++) begin
            bus_if.address = bus_if.address + 16'h1357;
            bus_if.data    = bus_if.data + 8'h5A;
            @(negedge clk);
        end
        chk("align", cyc % 32, 19);
        bus_if.address   = 16'h0040;
        bus_if.data      = 8'h00;
        bus_if.bus_valid = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            chk("act_cnt", dut.act_cnt, (i < 5) ? 10 - i : ((i < 15) ? 15 - i : 0));
            if ((cyc % 32) >= 2 && (cyc % 32) <= 4)
                chk("act_dp", seg[7], !(i >= 1 && i <= 15));
            bus_if.bus_valid = (i == 4);
            bus_if.address   = (i == 4) ? 16'h0040 : (16'hA5C3 ^ 16'(i));
            bus_if.data      = (i == 4) ? 8'h00 : (8'h9E ^ 8'(i));
        end
        bus_if.address = 16'hFFFF;
        bus_if.data    = 8'hFF;
        repeat (4) @(negedge clk);
        check_frame("cap", CAP_TBL);

        bus_if.mode      = 2'b10;
        bus_if.address   = 16'hBEEF;
        bus_if.data      = 8'h77;
        bus_if.bus_valid = 1'b1;
        check_frame("hold", CAP_TBL);
        chk("hold_act", dut.act_cnt, 0);

        bus_if.lzb = 1'b1;
        check_frame("lzb", LZB_TBL);

        // Asynchronous reset in the middle of a lit slot.
        for (int n = 0; n < 8 && (cyc % 4) != 2; n++) @(negedge clk);
        chk("mid_lit", an == 8'hFF, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", an, 8'hFF);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_tick", frame_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel1_an", an, 8'hFF);
        @(negedge clk);
        chk("mid_rel2_an", an, 8'hFE);
        chk("mid_rel2_seg", seg, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_display_scanner.md
# bus_display_scanner

Parametrised multiplexed seven-segment driver for observing the CPU address/data bus on the board display. It latches the bus according to a selectable capture mode and scans a configurable number of digits with a programmable per-digit period. Each slot begins with an anti-ghosting blank interval, and the block supports optional leading-zero blanking and a stretched bus-activity indicator on a decimal point. It sits between the CPU bus probe and the board's `seg`/`an` pins.

## Interface
- `NUM_DIGITS`, 8: physical digits scanned (2..8).
- `ADDR_W`, 16: address width; multiple of 4, `ADDR_W/4 + DATA_W/4 <= NUM_DIGITS`.
- `DATA_W`, 8: data width; multiple of 4.
- `SCAN_DIV`, 100000: clocks per digit slot; `>= 2`.
- `BLANK_CYC`, 2000: clocks at slot start with all anodes off; `< SCAN_DIV`.
- `ACT_CYC`, 10000000: clocks the activity DP stays lit after a capture; `>= 1`.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `address`  in  ADDR_W: bus address.
- `data`  in  DATA_W: bus data.
- `bus_valid`  in  1: bus transfer strobe, sampled each clock.
- `mode`  in  2: 00 live, 01 capture-on-strobe, 10/11 hold.
- `lzb`  in  1: leading-zero blanking enable.
- `seg`  out  8: active-low segments; bit 7 = DP, bits 6:0 = g..a.
- `an`  out  NUM_DIGITS: active-low anodes, one-hot-low or all ones.
- `frame_tick`  out  1: one-clock pulse when the digit index wraps to 0.

## Operation
- **Capture registers `cap_addr`/`cap_data`:**
  - Live: load every clock.
  - Capture: load only on clocks with `bus_valid` = 1.
  - Hold: never load.
  - A mode change takes effect on the next clock. Entering hold freezes the last loaded values.
- **Activity counter `act_cnt`:**
  - Loads `ACT_CYC` on any clock where `bus_valid` = 1 and mode ≠ hold.
  - Otherwise decrements to 0 and saturates there.
  - A strobe arriving while the counter is non-zero reloads it.
- **Digit layout:**
  - Digits 0..`ADDR_W/4`−1 show address nibbles, LSN at digit 0.
  - Digits `NUM_DIGITS`−`DATA_W/4`..`NUM_DIGITS`−1 show data nibbles, LSN at the lowest of those digits.
  - Remaining digits are blank: anode still driven, `seg` = 0xFF.
- **Leading-zero blanking (`lzb` = 1):** within each field, a zero nibble is blanked if every more-significant nibble of that field is zero. The field's least-significant digit is never blanked. Value 0 shows a single "0".
- **Decimal point:** DP (`seg[7]` = 0) is lit only on digit 0 while `act_cnt` ≠ 0.
- **Hex encoding:** active-low, gfedcba.
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78
  - 8→0x00, 9→0x10, A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E
- **Scan counter `div_cnt`:**
  - Counts 0..`SCAN_DIV`−1.
  - At terminal count, `div_cnt` → 0 and `idx` advances.
  - `idx` wraps `NUM_DIGITS`−1 → 0, and `frame_tick` pulses on that wrap.
- **Reset values:** `div_cnt` = 0, `idx` = 0, captures = 0, `act_cnt` = 0, `an` = all ones, `seg` = 0xFF, `frame_tick` = 0.
- **Reset mid-scan:** asynchronous assertion forces the reset values immediately.

## Timing
- `seg`, `an` and `frame_tick` are registered. Pins reflect `idx`, `div_cnt`, captures and `act_cnt` from the previous clock, i.e. one clock of latency.
- **Slot blanking:** while `div_cnt` < `BLANK_CYC`, `an` = all ones and `seg` = 0xFF. Otherwise `an[idx]` = 0.
- **Capture to display:** a capture at edge N is visible on pins at edge N+1, if the current digit is displaying.
- **Frame period:** `NUM_DIGITS`·`SCAN_DIV` clocks.
- **`frame_tick` placement:** high for the single clock following the `idx` wrap edge.
- Release from reset: the first slot (digit 0) starts at the first edge after deassertion.

## Structure
- **`bus_display_pkg`:**
  - Mode constants `MODE_LIVE`, `MODE_CAPTURE`, `MODE_HOLD`.
  - `SEG_BLANK` = 8'hFF.
  - 16-entry hex segment constant table.
- **Sub-module `hex_seg_decoder`:** 4-bit nibble plus blank flag in, 7-bit pattern out; purely combinational.
- Top-level holds the capture registers, activity counter, scan/index counters, leading-zero logic and output registers.

## Test plan
Benches use `NUM_DIGITS`=8, `SCAN_DIV`=4, `BLANK_CYC`=1, `ACT_CYC`=10.

- **Reset:** hold `rst_n`=0 mid-scan → `an`=0xFF, `seg`=0xFF within the same cycle. Release → `an`=0xFE appears 2 clocks later (one blank clock, then registered).
- **Live scan:** mode 00, `address`=0x12AF, `data`=0x3C, `lzb`=0.
  - One frame shows digits 0..7 as 0x0E, 0x08, 0x24, 0x79, blank, blank, 0x46, 0x30.
  - `frame_tick` pulses once per 32 clocks.
- **Capture:** mode 01, bus toggling, `bus_valid` pulsed once with `address`=0x0040, `data`=0x00.
  - Display holds 0x0040/0x00 afterward.
  - DP lit on digit 0 for exactly 10 clocks after the strobe; a second strobe at clock 5 extends it to clock 15.
- **Hold:** switch to mode 10 and change the bus with `bus_valid` high → display and `act_cnt` unchanged.
- **Leading-zero blanking:** `lzb`=1, `address`=0x0040, `data`=0x00.
  - Digits 3 and 2 blank; digits 1, 0 show "4", "0".
  - Digit 7 blank; digit 6 shows "0".
- **Blank interval:** every slot's first clock → `an`=0xFF. Exactly one anode is low on the remaining 3 clocks.
